// File: rtl/csr_file.sv
// Machine-mode CSR unit: executes CSRRW/CSRRS/CSRRC with a one-cycle writeback,
// applies commit-driven trap entry and MRET, and maintains counters and interrupt state.
module csr_file #(
    parameter int XLEN   = 64,
    parameter int RB     = 6,
    parameter int CMT_W  = 2,
    parameter int HARTID = 0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       flush,
    input  logic                       csr_exeparam_valid,
    input  logic [2:0]                 csr_fun,
    input  logic [5+RB-1:0]            csr_rd0,
    input  logic [XLEN-1:0]            csr_op,
    input  logic [11:0]                csr_addr,
    output logic                       csr_writeback_valid,
    output logic [XLEN-1:0]            csr_res_qout,
    output logic [5+RB-1:0]            csr_rd0_qout,
    output logic                       csr_illegal_qout,
    input  logic                       trap_valid,
    input  logic                       trap_is_int,
    input  logic [3:0]                 trap_cause,
    input  logic [XLEN-1:0]            trap_pc,
    input  logic [XLEN-1:0]            trap_tval,
    input  logic                       mret_valid,
    input  logic [$clog2(CMT_W+1)-1:0] retire_cnt,
    input  logic                       irq_ext,
    input  logic                       irq_tmr,
    input  logic                       irq_sft,
    output logic                       int_req,
    output logic [XLEN-1:0]            trap_target,
    output logic [XLEN-1:0]            mepc_qout
);

    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [11:0] A_MIMPID    = 12'hF13;
    localparam logic [11:0] A_MHARTID   = 12'hF14;
    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;

    localparam logic [XLEN-1:0] MISA_VAL   = {(XLEN == 32) ? 2'b01 : 2'b10, {(XLEN-11){1'b0}}, 9'h100};
    localparam logic [XLEN-1:0] MPP_BITS   = XLEN'(16'h1800);
    localparam logic [XLEN-1:0] MIE_MASK   = XLEN'(16'h0888);
    localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'(2);
    localparam logic [XLEN-1:0] MEPC_MASK  = ~XLEN'(3);

    logic            mstatus_mie;
    logic            mstatus_mpie;
    logic [XLEN-1:0] mie_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mcycle_q;
    logic [XLEN-1:0] minstret_q;

    logic [XLEN-1:0] mip_v;
    logic [XLEN-1:0] mstatus_v;
    logic [XLEN-1:0] rd_val;
    logic            implemented;
    logic            read_only;

    assign mip_v     = XLEN'({irq_ext, 3'b000, irq_tmr, 3'b000, irq_sft, 3'b000});
    assign mstatus_v = MPP_BITS | (XLEN'(mstatus_mie) << 3) | (XLEN'(mstatus_mpie) << 7);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        rd_val      = '0;
        implemented = 1'b1;
        read_only   = 1'b0;
        case (csr_addr)
            A_MVENDORID, A_MARCHID, A_MIMPID: read_only = 1'b1;
            A_MHARTID: begin
                read_only = 1'b1;
                rd_val    = XLEN'(HARTID);
            end
            A_MSTATUS:  rd_val = mstatus_v;
            A_MISA: begin
                read_only = 1'b1;
                rd_val    = MISA_VAL;
            end
            A_MIE:      rd_val = mie_q;
            A_MTVEC:    rd_val = mtvec_q;
            A_MSCRATCH: rd_val = mscratch_q;
            A_MEPC:     rd_val = mepc_q;
            A_MCAUSE:   rd_val = mcause_q;
            A_MTVAL:    rd_val = mtval_q;
            A_MIP: begin
                read_only = 1'b1;
                rd_val    = mip_v;
            end
            A_MCYCLE:   rd_val = mcycle_q;
            A_MINSTRET: rd_val = minstret_q;
            default:    implemented = 1'b0;
        endcase
    end

    logic            is_rw;
    logic            is_rs;
    logic            wants_write;
    logic            illegal;
    logic            wr_fire;
    logic [XLEN-1:0] wr_data;
    logic [XLEN-1:0] res_next;

    assign is_rw       = csr_fun[2];
    assign is_rs       = csr_fun[1];
    assign wants_write = is_rw | ((csr_fun[1] | csr_fun[0]) & (|csr_op));
    assign illegal     = ~implemented | (read_only & wants_write);
    assign wr_data     = is_rw ? csr_op : (is_rs ? (rd_val | csr_op) : (rd_val & ~csr_op));
    assign wr_fire     = csr_exeparam_valid & ~flush & ~illegal & wants_write;
    assign res_next    = (illegal || (is_rw && csr_rd0 == '0)) ? '0 : rd_val;

    // Writes to fields that a same-cycle trap or MRET also updates are dropped.
    logic we_mstatus, we_mie, we_mtvec, we_mscratch, we_mepc, we_mcause, we_mtval;
    logic we_mcycle, we_minstret;

    assign we_mstatus  = wr_fire & (csr_addr == A_MSTATUS) & ~trap_valid & ~mret_valid;
    assign we_mie      = wr_fire & (csr_addr == A_MIE);
    assign we_mtvec    = wr_fire & (csr_addr == A_MTVEC);
    assign we_mscratch = wr_fire & (csr_addr == A_MSCRATCH);
    assign we_mepc     = wr_fire & (csr_addr == A_MEPC) & ~trap_valid;
    assign we_mcause   = wr_fire & (csr_addr == A_MCAUSE) & ~trap_valid;
    assign we_mtval    = wr_fire & (csr_addr == A_MTVAL) & ~trap_valid;
    assign we_mcycle   = wr_fire & (csr_addr == A_MCYCLE);
    assign we_minstret = wr_fire & (csr_addr == A_MINSTRET);

    // NOTE: state registers use non-blocking assignments so every read in this edge sees the old value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_q        <= '0;
            mtvec_q      <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mtval_q      <= '0;
            mscratch_q   <= '0;
            mcycle_q     <= '0;
            minstret_q   <= '0;
        end else begin
            if (trap_valid) begin
                mepc_q       <= trap_pc & MEPC_MASK;
                mcause_q     <= {trap_is_int, {(XLEN-5){1'b0}}, trap_cause};
                mtval_q      <= trap_tval;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (mret_valid) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end

            if (we_mstatus) begin
                mstatus_mie  <= wr_data[3];
                mstatus_mpie <= wr_data[7];
            end
            if (we_mie)      mie_q      <= wr_data & MIE_MASK;
            if (we_mtvec)    mtvec_q    <= wr_data & MTVEC_MASK;
            if (we_mscratch) mscratch_q <= wr_data;
            if (we_mepc)     mepc_q     <= wr_data & MEPC_MASK;
            if (we_mcause)   mcause_q   <= wr_data;
            if (we_mtval)    mtval_q    <= wr_data;

            mcycle_q   <= we_mcycle   ? wr_data : mcycle_q + XLEN'(1);
            minstret_q <= we_minstret ? wr_data : minstret_q + XLEN'(retire_cnt);
        end
    end

    // Flush kills both the instruction issuing now and the result currently on the outputs.
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            csr_writeback_valid <= 1'b0;
            csr_res_qout        <= '0;
            csr_rd0_qout        <= '0;
            csr_illegal_qout    <= 1'b0;
        end else begin
            csr_writeback_valid <= csr_exeparam_valid;
            csr_res_qout        <= csr_exeparam_valid ? res_next : '0;
            csr_rd0_qout        <= csr_exeparam_valid ? csr_rd0 : '0;
            csr_illegal_qout    <= csr_exeparam_valid & illegal;
        end
    end

    logic [XLEN-1:0] tvec_base;

    assign tvec_base   = {mtvec_q[XLEN-1:2], 2'b00};
    assign trap_target = (mtvec_q[0] && trap_is_int) ? tvec_base + (XLEN'(trap_cause) << 2) : tvec_base;
    assign mepc_qout   = mepc_q;
    assign int_req     = mstatus_mie & (|(mip_v & mie_q));

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR unit of the backend execute stage; a successor to the single-hart, fixed-width CSR executor.
- Executes CSRRW/CSRRS/CSRRC and returns the old CSR value to writeback with one-cycle latency.
- Adds over the previous generation:
  - commit-driven trap entry and MRET;
  - mcycle/minstret counters;
  - mscratch;
  - interrupt pending/enable logic;
  - illegal-access reporting;
  - XLEN, rename-width and commit-width parameters.

Parameters:
- XLEN, 64, data width of all CSRs and operands (32 or 64).
- RB, 6, rename index width; rd tag is 5+RB bits.
- CMT_W, 2, max instructions retired per cycle (minstret increment width is $clog2(CMT_W+1)).
- HARTID, 0, value returned by mhartid.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- flush  in  1  kills the in-flight CSR instruction (same cycle and output stage).
- csr_exeparam_valid  in  1  CSR instruction issued this cycle.
- csr_fun  in  3  one-hot {rw,rs,rc}.
- csr_rd0  in  5+RB  destination tag.
- csr_op  in  XLEN  rs1 value or zero-extended uimm.
- csr_addr  in  12  CSR address.
- csr_writeback_valid  out  1  result valid.
- csr_res_qout  out  XLEN  old CSR value.
- csr_rd0_qout  out  5+RB  registered tag.
- csr_illegal_qout  out  1  registered illegal-access flag, aligned with writeback_valid.
- trap_valid  in  1  commit takes trap.
- trap_is_int  in  1  trap is an interrupt.
- trap_cause  in  4  exception/interrupt code.
- trap_pc  in  XLEN  pc written to mepc.
- trap_tval  in  XLEN  value written to mtval.
- mret_valid  in  1  commit executes MRET.
- retire_cnt  in  $clog2(CMT_W+1)  instructions retired this cycle.
- irq_ext / irq_tmr / irq_sft  in  1 each  level interrupt lines.
- int_req  out  1  interrupt pending and enabled.
- trap_target  out  XLEN  redirect pc for the current trap.
- mepc_qout  out  XLEN  mepc, used as the MRET target.

Behaviour:
- **Reset** (RST high at posedge):
  - mstatus.MIE=0, MPIE=0, MPP=2'b11.
  - mie, mtvec, mepc, mcause, mtval, mscratch, mcycle, minstret all 0.
  - All output registers 0.
- **Implemented CSRs:**
  - 0xF11-0xF14: read-only. mvendorid=0, marchid=0, mimpid=0, mhartid=HARTID.
  - 0x300 mstatus: only MIE[3], MPIE[7] writable. MPP[12:11] reads 11. Other bits read 0.
  - 0x301 misa: read-only. MXL=1 for XLEN=32, 2 for XLEN=64. Bit I set.
  - 0x304 mie: only bits 3, 7, 11 writable.
  - 0x305 mtvec: all bits writable except bit1, which reads 0.
  - 0x340 mscratch, 0x341 mepc, 0x343 mtval: mepc bits[1:0] read 0.
  - 0x342 mcause.
  - 0x344 mip: read-only. MEIP[11]=irq_ext, MTIP[7]=irq_tmr, MSIP[3]=irq_sft, sampled combinationally.
  - 0xB00 mcycle, 0xB02 minstret.
- **CSR instruction:**
  - Combinational read of the old value.
  - New value: rw→op, rs→old|op, rc→old&~op. Masked by the writable-field mask.
  - No write when (rs|rc) and op==0.
  - No read when rw and rd==0: result is 0; the write still happens.
  - All outputs registered: result appears the cycle after csr_exeparam_valid.
  - The CSR update is visible to an instruction issued the following cycle.
- **Illegal access:**
  - Unimplemented address, or a write to a read-only address (rw always counts as a write; rs/rc only when op≠0).
  - Effect: no state change, res=0, csr_illegal_qout=1 with writeback_valid=1.
- **flush:**
  - Asserted in the issue cycle: suppresses the CSR write, and next-cycle valid/res/rd0/illegal are 0.
  - Asserted in the output cycle: clears the output registers.
  - Does not affect trap/mret/counters.
- **Trap entry** (trap_valid):
  - mepc←trap_pc with bits[1:0] cleared.
  - mcause←{trap_is_int, zeros, trap_cause}.
  - mtval←trap_tval.
  - MPIE←MIE, MIE←0.
  - trap_target (combinational): mtvec base (bits[XLEN-1:2]<<2). If mtvec[0]=1 and trap_is_int, base+4*trap_cause.
- **mret_valid:** MIE←MPIE, MPIE←1.
- **Same-cycle priority:** trap_valid > mret_valid > CSR write. A CSR write to a field updated by the winning event is dropped; the CSR instruction still writes back its old value.
- **Counters:**
  - mcycle +1 every cycle. minstret +retire_cnt.
  - Both wrap modulo 2^XLEN.
  - A CSR write to a counter in a cycle wins over that cycle's increment. Counting resumes the next cycle from the written value.
- **int_req** = MIE & |(mip & mie), combinational.

Test Plan:
- **RW/read:** reset; csrrw mscratch, op=0x1234_5678, rd=5 → next cycle res=0, rd0=5, valid=1. csrrs mscratch, op=0 → res=0x12345678, no write.
- **Set/clear masking:** csrrs mstatus, op=0xFFFF → later read returns 0x1888 (MIE, MPIE, MPP). csrrc op=0x8 → reads 0x1880.
- **Trap/MRET:** mstatus.MIE=1, mtvec=0x8000_0001; trap_valid, is_int=1, cause=7, pc=0x8000_0102 → trap_target=0x8000_001C, mepc=0x8000_0100, mcause=0x8000…0007, MIE=0, MPIE=1. mret → MIE=1.
- **Illegal/flush:** csrrw 0xF11 → illegal=1, res=0, mvendorid still 0. csrrw mepc together with flush → valid=0 next cycle, mepc unchanged.
- **Counters/priority:** retire_cnt=2 for 3 cycles → minstret=6. csrrw mcycle=0xFFFF…FFFF → next cycle 0xFFFF…FFFF, following cycle 0 (wrap). Simultaneous trap and csrrw mepc → mepc=trap_pc.
- **Interrupt:** mie=0x800, MIE=1, irq_ext=1 → int_req=1. Deassert irq_ext → int_req=0 in the same cycle.
